// File: rtl/shift_register_pkg.sv
// Shared types for shift_register: default width and the per-edge operation code.
// Optional bidirectional shifting is enabled by SHIFT_REGISTER_BIDIR_EN.
package shift_register_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_HOLD    = 2'd0,
        OP_LOAD    = 2'd1,
        OP_SHIFT_R = 2'd2,
        OP_SHIFT_L = 2'd3
    } op_t;

endpackage

// File: rtl/shift_register_cell.sv
// One bit of shift_register: 4:1 next-state mux plus a synchronous-reset flop.
// Used identically whether or not SHIFT_REGISTER_BIDIR_EN is defined.
module shift_register_cell
    import shift_register_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  op_t  op_i,
    input  logic d_i,
    input  logic shr_i,
    input  logic shl_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    // shr_i is the bit arriving on a right shift (upper neighbour or SI),
    // shl_i the bit arriving on a left shift (lower neighbour or SI).
    always_comb begin
        q_d = q_q;
        case (op_i)
            OP_HOLD:    q_d = q_q;
            OP_LOAD:    q_d = d_i;
            OP_SHIFT_R: q_d = shr_i;
            OP_SHIFT_L: q_d = shl_i;
            default:    q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/shift_register.sv
// Parallel-load, serial-in shift register: priority reset > load > shift > hold.
// Define SHIFT_REGISTER_BIDIR_EN to add the Dir port and left shifting.
module shift_register
    import shift_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             L,
    input  logic             Sh,
    input  logic             SI,
`ifdef SHIFT_REGISTER_BIDIR_EN
    input  logic             Dir,
`endif
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             SO
);

    op_t              op;
    logic [WIDTH-1:0] shr_in;
    logic [WIDTH-1:0] shl_in;

    // Reset lives in each cell's flop, so the decoder only arbitrates load vs shift.
    always_comb begin
        op = OP_HOLD;
        if (L) begin
            op = OP_LOAD;
        end else if (Sh) begin
`ifdef SHIFT_REGISTER_BIDIR_EN
            op = Dir ? OP_SHIFT_L : OP_SHIFT_R;
`else
            op = OP_SHIFT_R;
`endif
        end
    end

    assign shr_in = {SI, Q[WIDTH-1:1]};
    assign shl_in = {Q[WIDTH-2:0], SI};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        shift_register_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .op_i  (op),
            .d_i   (D[i]),
            .shr_i (shr_in[i]),
            .shl_i (shl_in[i]),
            .q_o   (Q[i])
        );
    end

`ifdef SHIFT_REGISTER_BIDIR_EN
    assign SO = Dir ? Q[WIDTH-1] : Q[0];
`else
    assign SO = Q[0];
`endif

endmodule

// File: tb/tb_shift_register.sv
// Scoreboard bench for shift_register; covers SHIFT_REGISTER_BIDIR_EN when defined.
module tb_shift_register;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] q;
        logic         so;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         L   = 1'b0;
    logic         Sh  = 1'b0;
    logic         SI  = 1'b0;
    logic [W-1:0] D   = '0;
    logic [W-1:0] Q;
    logic         SO;
`ifdef SHIFT_REGISTER_BIDIR_EN
    logic         Dir = 1'b0;
`endif

    exp_t         sb[$];
    logic [W-1:0] model_q = '0;
    int           n_cmp = 0;
    int           n_bad = 0;
    bit           stim_done = 0;

    shift_register #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .L   (L),
        .Sh  (Sh),
        .SI  (SI),
`ifdef SHIFT_REGISTER_BIDIR_EN
        .Dir (Dir),
`endif
        .D   (D),
        .Q   (Q),
        .SO  (SO)
    );

    always #5 clk = ~clk;

    // Drive one edge's inputs on the falling edge and queue what Q/SO must be after it.
    task automatic step(input logic r, input logic l, input logic sh,
                        input logic si, input logic [W-1:0] d, input string nm);
        exp_t e;
        bit   left;
        @(negedge clk);
        rst = r; L = l; Sh = sh; SI = si; D = d;
        left = 1'b0;
`ifdef SHIFT_REGISTER_BIDIR_EN
        left = Dir;
`endif
        if (r)
            model_q = '0;
        else if (l)
            model_q = d;
        else if (sh && !left)
            model_q = (model_q >> 1) | (W'(si) << (W - 1));
        else if (sh && left)
            model_q = (model_q << 1) | W'(si);
        e.q    = model_q;
        e.so   = left ? model_q[W-1] : model_q[0];
        e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: one registered result per edge, checked 1 time unit after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (Q !== e.q) begin
                    n_bad++;
                    $display("FAIL %s Q: got %b expected %b", e.name, Q, e.q);
                end
                n_cmp++;
                if (SO !== e.so) begin
                    n_bad++;
                    $display("FAIL %s SO: got %b expected %b", e.name, SO, e.so);
                end
            end
        end
    end

    initial begin
        // Reset beats load.
        step(1, 1, 0, 0, 4'b1111, "reset0");
        step(1, 1, 0, 0, 4'b1111, "reset1");
        // Shift in zero then ones.
        step(0, 0, 1, 0, 4'b0000, "shz");
        step(0, 0, 1, 1, 4'b0000, "sh1a");
        step(0, 0, 1, 1, 4'b0000, "sh1b");
        step(0, 0, 1, 1, 4'b0000, "sh1c");
        // Load, then hold while D changes.
        step(0, 1, 0, 0, 4'b1011, "load");
        step(0, 0, 0, 0, 4'b1010, "hold");
        // Load wins over shift, then shift resumes.
        step(0, 1, 1, 0, 4'b0110, "ldprio");
        step(0, 0, 1, 1, 4'b0000, "shafter");
        // Reset mid-shift.
        step(1, 0, 0, 0, 4'b0000, "rclr");
        step(0, 0, 1, 1, 4'b0000, "rs1");
        step(0, 0, 1, 1, 4'b0000, "rs2");
        step(1, 0, 1, 1, 4'b0000, "rmid");
        step(0, 0, 1, 1, 4'b0000, "rresume");
        // Saturation to all-ones after W shifts of constant SI.
        for (int i = 0; i < W; i++) step(0, 0, 1, 1, 4'b0000, "sat");
`ifdef SHIFT_REGISTER_BIDIR_EN
        step(0, 1, 0, 0, 4'b0001, "bload");
        Dir = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 4'b0000, "bleft");
        Dir = 1'b0;
`endif
        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
`ifdef SHIFT_REGISTER_BIDIR_EN
            Dir = 1'($urandom);
`endif
            step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom), W'($urandom), "rand");
        end
        stim_done = 1;
    end

    initial begin
        int guard;
        guard = 0;
        while (!stim_done && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (!stim_done || sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: done=%0d pending=%0d expected done=1 pending=0",
                     stim_done, sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
